// File: rtl/instruction_memory_server.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_server
// Description : Owns the instruction RAM behind the mesh round-robin memory
//               arbiter. One read is accepted from IDLE, the addressed word is
//               sampled immediately, and it is presented with a single-cycle
//               mem_ready strobe exactly READ_LATENCY cycles later. A host
//               write port loads the program at any time. Two saturating
//               counters report reads served and requester stall cycles.
//
// Ports       :
//   clk          in   1                   clock
//   rst          in   1                   synchronous active-high reset
//   mem_addr     in   MEMORY_ADDR_WIDTH   read address from the arbiter
//   mem_valid    in   1                   read request
//   mem_ready    out  1                   one-cycle response strobe
//   mem_data     out  MEMORY_WIDTH        response word (held between strobes)
//   wr_en        in   1                   host program write enable
//   wr_addr      in   MEMORY_ADDR_WIDTH   host write address
//   wr_data      in   MEMORY_WIDTH        host write data
//   busy         out  1                   read in flight (WAIT or RESP)
//   read_count   out  COUNTER_WIDTH       reads served, saturating
//   stall_count  out  COUNTER_WIDTH       cycles mem_valid & !mem_ready, sat.
//
// Revision    : 1.0  initial release
// ============================================================================
module instruction_memory_server #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int READ_LATENCY      = 2,
    parameter int COUNTER_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    output logic [MEMORY_WIDTH-1:0]      mem_data,
    input  logic                         wr_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEMORY_WIDTH-1:0]      wr_data,
    output logic                         busy,
    output logic [COUNTER_WIDTH-1:0]     read_count,
    output logic [COUNTER_WIDTH-1:0]     stall_count
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter guard
    // ------------------------------------------------------------------------
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
            $error("instruction_memory_server: READ_LATENCY must be in 1..8");
        end
    endgenerate

    localparam int                 c_DEPTH    = 2 ** MEMORY_ADDR_WIDTH;
    localparam int                 c_LAT_W    = 4;
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(READ_LATENCY - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [c_LAT_W-1:0]      w_lat_cnt_next;
    logic                    w_accept;
    logic                    w_ready;

    logic [MEMORY_WIDTH-1:0] r_mem [c_DEPTH];
    logic [MEMORY_WIDTH-1:0] r_sample;
    logic [MEMORY_WIDTH-1:0] r_last;

    logic [COUNTER_WIDTH-1:0] r_read_count;
    logic [COUNTER_WIDTH-1:0] r_stall_count;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_lat_cnt <= w_lat_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state. The counter is loaded with READ_LATENCY-1 at accept and
    // the WAIT state is left when it reads 1, so WAIT lasts READ_LATENCY-1
    // cycles and RESP lands exactly READ_LATENCY cycles after the accept.
    // Requests arriving in WAIT or RESP are deliberately ignored; a request
    // still held after RESP is taken on the following IDLE cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_lat_cnt_next = r_lat_cnt;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_accept       = 1'b1;
                    w_lat_cnt_next = c_LAT_LOAD;
                    w_state_next   = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // "<=" rather than "==" so a corrupted zero count cannot lock
                // the server in WAIT forever.
                if (r_lat_cnt <= c_LAT_ONE) begin
                    w_lat_cnt_next = '0;
                    w_state_next   = S_RESP;
                end else begin
                    w_lat_cnt_next = r_lat_cnt - c_LAT_ONE;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next   = S_IDLE;
                w_lat_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Instruction RAM. The accept-cycle read uses the pre-edge contents, so a
    // same-cycle write to the same address returns the old word. Sampling at
    // accept also makes later writes and requester address changes invisible
    // to the pending response. Contents are intentionally not reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_accept) begin
            r_sample <= r_mem[mem_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Response data: the sampled word is shown during RESP and then retained
    // in r_last, so mem_data only ever changes in a RESP cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (r_state == S_RESP) begin
            r_last <= r_sample;
        end
    end

    assign w_ready   = (r_state == S_RESP);
    assign mem_ready = w_ready;
    assign mem_data  = w_ready ? r_sample : r_last;
    assign busy      = (r_state == S_WAIT) || (r_state == S_RESP);

    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_ready && (r_read_count != {COUNTER_WIDTH{1'b1}})) begin
                r_read_count <= r_read_count + 1'b1;
            end
            if (mem_valid && !w_ready &&
                (r_stall_count != {COUNTER_WIDTH{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_memory_server
// Description : Scoreboard bench for instruction_memory_server. Instance A
//               runs READ_LATENCY=2 with 32-bit counters, instance B runs
//               READ_LATENCY=1 with 4-bit counters. Stimulus pushes the
//               expected {word, response cycle} into a per-instance queue; a
//               negedge monitor pops and compares on every mem_ready strobe.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_memory_server;

    localparam int W  = 16;
    localparam int AW = 11;

    typedef struct packed {
        logic [W-1:0] data;
        logic [31:0]  cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [31:0] cyc = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic          rst_a, a_valid, a_ready, a_wr_en, a_busy;
    logic [AW-1:0] a_addr, a_wr_addr;
    logic [W-1:0]  a_data, a_wr_data;
    logic [31:0]   a_rc, a_sc;

    // Instance B signals
    logic          rst_b, b_valid, b_ready, b_wr_en, b_busy;
    logic [AW-1:0] b_addr, b_wr_addr;
    logic [W-1:0]  b_data, b_wr_data;
    logic [3:0]    b_rc, b_sc;

    instruction_memory_server #(
        .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW),
        .READ_LATENCY(2), .COUNTER_WIDTH(32)
    ) dut_a (
        .clk(clk), .rst(rst_a),
        .mem_addr(a_addr), .mem_valid(a_valid),
        .mem_ready(a_ready), .mem_data(a_data),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .read_count(a_rc), .stall_count(a_sc)
    );

    instruction_memory_server #(
        .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW),
        .READ_LATENCY(1), .COUNTER_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst(rst_b),
        .mem_addr(b_addr), .mem_valid(b_valid),
        .mem_ready(b_ready), .mem_data(b_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .read_count(b_rc), .stall_count(b_sc)
    );

    function automatic exp_t mk(input logic [W-1:0] d, input logic [31:0] c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (a_ready === 1'b1) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_resp: unexpected strobe data=%h cycle=%0d, required none",
                         a_data, cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (a_data !== e.data || cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL a_resp: got data=%h cycle=%0d, required data=%h cycle=%0d",
                             a_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_ready === 1'b1) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_resp: unexpected strobe data=%h cycle=%0d, required none",
                         b_data, cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (b_data !== e.data || cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL b_resp: got data=%h cycle=%0d, required data=%h cycle=%0d",
                             b_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] t;
        rst_a = 1'b1; a_valid = 1'b0; a_addr = '0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        rst_b = 1'b1; b_valid = 1'b0; b_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        tick(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(1);

        check("a_reset_ready", {31'd0, a_ready}, 32'd0);
        check("a_reset_data",  {16'd0, a_data}, 32'd0);
        check("a_reset_busy",  {31'd0, a_busy}, 32'd0);
        check("a_reset_rc",    a_rc, 32'd0);
        check("a_reset_sc",    a_sc, 32'd0);
        check("b_reset_rc",    {28'd0, b_rc}, 32'd0);

        // Program load: A gets 5/6/7, B gets 5/6
        a_wr_en = 1'b1; a_wr_addr = 11'd5; a_wr_data = 16'hABCD;
        b_wr_en = 1'b1; b_wr_addr = 11'd5; b_wr_data = 16'hABCD;
        tick();
        a_wr_addr = 11'd6; a_wr_data = 16'h1234;
        b_wr_addr = 11'd6; b_wr_data = 16'h1234;
        tick();
        a_wr_addr = 11'd7; a_wr_data = 16'h0001;
        b_wr_en = 1'b0;
        tick();
        a_wr_en = 1'b0;
        tick();

        // A: held request, response at T+2, re-accept at T+3 -> response T+5
        t = cyc;
        a_valid = 1'b1; a_addr = 11'd5;
        qa.push_back(mk(16'hABCD, t + 2));
        qa.push_back(mk(16'hABCD, t + 5));
        tick(4);
        a_valid = 1'b0;
        tick(2);
        check("a_held_rc",   a_rc, 32'd2);
        check("a_held_sc",   a_sc, 32'd3);
        check("a_held_busy", {31'd0, a_busy}, 32'd0);
        check("a_data_hold", {16'd0, a_data}, 32'h0000ABCD);

        // A: same-cycle accept and write to address 7 returns the old word;
        // request dropped the cycle after accept.
        t = cyc;
        a_valid = 1'b1; a_addr = 11'd7;
        a_wr_en = 1'b1; a_wr_addr = 11'd7; a_wr_data = 16'h7777;
        qa.push_back(mk(16'h0001, t + 2));
        tick();
        a_valid = 1'b0; a_wr_en = 1'b0;
        tick(2);
        // Second read sees 0x7777; a write while in flight must not leak in
        t = cyc;
        a_valid = 1'b1;
        qa.push_back(mk(16'h7777, t + 2));
        tick();
        a_valid = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 11'd7; a_wr_data = 16'h5555;
        tick();
        a_wr_en = 1'b0;
        tick(2);
        check("a_rbw_rc", a_rc, 32'd4);
        check("a_rbw_sc", a_sc, 32'd5);
        check("a_rbw_data_hold", {16'd0, a_data}, 32'h00007777);
        t = cyc;
        a_valid = 1'b1;
        qa.push_back(mk(16'h5555, t + 2));
        tick();
        a_valid = 1'b0;
        tick(3);
        check("a_third_rc", a_rc, 32'd5);
        check("a_third_sc", a_sc, 32'd6);

        // A: reset during WAIT with the request held
        a_valid = 1'b1; a_addr = 11'd6;
        tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("a_mid_rst_busy",  {31'd0, a_busy}, 32'd0);
        check("a_mid_rst_ready", {31'd0, a_ready}, 32'd0);
        check("a_mid_rst_rc",    a_rc, 32'd0);
        check("a_mid_rst_sc",    a_sc, 32'd0);
        check("a_mid_rst_data",  {16'd0, a_data}, 32'd0);
        qa.push_back(mk(16'h1234, cyc + 2));
        tick();
        check("a_post_rst_accept_busy", {31'd0, a_busy}, 32'd1);
        a_valid = 1'b0;
        tick(3);
        check("a_post_rst_rc", a_rc, 32'd1);
        check("a_post_rst_sc", a_sc, 32'd1);

        // B (latency 1): addr 5 then addr 6 back-to-back, valid held
        t = cyc;
        b_valid = 1'b1; b_addr = 11'd5;
        qb.push_back(mk(16'hABCD, t + 1));
        tick();
        b_addr = 11'd6;
        qb.push_back(mk(16'h1234, t + 3));
        tick(2);
        b_valid = 1'b0;
        tick();
        check("b_b2b_sc", {28'd0, b_sc}, 32'd2);
        check("b_b2b_rc", {28'd0, b_rc}, 32'd2);

        // B: 18 more reads -> 20 total, 4-bit counters saturate at 15
        t = cyc;
        b_valid = 1'b1; b_addr = 11'd5;
        for (int i = 0; i < 18; i++) begin
            qb.push_back(mk(16'hABCD, t + 32'(2 * i + 1)));
        end
        tick(36);
        b_valid = 1'b0;
        tick(2);
        check("b_sat_rc", {28'd0, b_rc}, 32'd15);
        check("b_sat_sc", {28'd0, b_sc}, 32'd15);

        tick(3);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
